cpu_uart_rx_fifo: RTL and testbench
===================================

# cpu_uart_rx_fifo

Receive-side byte buffer between the UART receiver and the CPU's memory-mapped bus. It captures every byte strobed out of the receiver into a circular FIFO, so the single-cycle core can drain bytes by polling or on interrupt without losing back-to-back characters. It exposes a data register and a status/control register in the peripheral address space. Its read data joins the CPU's read-data multiplexer alongside data memory and the other peripherals.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- BASE_ADDR, 32'h4000_0020: byte address of the DATA register. STATUS is at BASE_ADDR+4.
- clk  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk rising edge.
- rx_status  in  1  one-cycle strobe from the UART receiver, synchronous to clk: rx_data is valid.
- rx_data  in  8  received byte.
- addr  in  32  ALU-computed bus address.
- wdata  in  32  store data.
- mem_rd  in  1  load in progress this cycle.
- mem_wr  in  1  store in progress this cycle.
- rdata  out  32  combinational read data; 0 when addr does not match.
- irq  out  1  level interrupt request.

## Operation
- DATA read (mem_rd, addr==BASE_ADDR): rdata = {24'b0, head byte}. Pop at the same clock edge.
- DATA read while the FIFO is empty: rdata = 0, no pop, no error.
- DATA writes are ignored.
- STATUS read: rdata = {count in bits [16:8], ien bit 3, overflow bit 2, full bit 1, nonempty bit 0}. All other bits are 0.
- STATUS write fields:
  - wdata[2]=1 clears overflow.
  - wdata[3] is loaded into ien.
  - wdata[4]=1 flushes: pointers and count go to 0. Stored bytes are discarded.
- Push on rx_status:
  - If the FIFO is not full, write rx_data at the tail.
  - If it is full and no pop occurs this cycle, drop the byte and set overflow. overflow is sticky.
- Simultaneous push and pop:
  - Both take effect.
  - count is unchanged, including when full.
  - When empty, only the push occurs, because a pop of an empty FIFO is a no-op.
- Flush in the same cycle as a push: flush wins, the byte is discarded, and overflow is unaffected.
- Overflow-clear and a new overflow in the same cycle: the set wins, so overflow=1.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, with full = (count==DEPTH).
- irq = ien & nonempty, driven from registered state only (no combinational path from inputs).

## Timing
- Reset values: pointers 0, count 0, overflow 0, ien 0, irq 0. rdata is 0 unless addr/mem_rd select a register.
- Reset takes priority over every other event. A byte strobed in the reset cycle is lost.
- Push latency: a byte strobed at edge N is readable on DATA in cycle N+1. nonempty and irq rise in cycle N+1.
- Pop: rdata is valid combinationally in the load cycle. The head advances at the end of that cycle.
- Two consecutive DATA loads return consecutive bytes.
- Storage has no read latency: registers, or asynchronous-read distributed RAM.

## Structure
- Shared package `cpu_uart_pkg`:
  - register offsets: DATA 0, STATUS 4;
  - STATUS bit positions: NONEMPTY 0, FULL 1, OVF 2, IEN 3, FLUSH 4, COUNT_LSB 8.
- Sub-module `cpu_fifo_core`:
  - generic synchronous FIFO with push/pop/flush, head data, count, full and empty;
  - parameterised WIDTH and DEPTH.
- The top block does the address decode, the register file, overflow/ien and irq.

## Test plan
- Reset, then read STATUS -> 0x0000_0000; irq=0; DATA read -> 0.
- Strobe 0x41, 0x42, 0x43 on consecutive cycles:
  - STATUS reads count=3, nonempty=1.
  - Three DATA loads return 0x41, 0x42, 0x43.
  - STATUS then reads 0.
- Fill 16 bytes 0x00..0x0F, then strobe 0xAA:
  - STATUS full=1, overflow=1, count=16.
  - Drain returns 0x00..0x0F; 0xAA is never returned.
  - Write 0x4 to STATUS -> overflow=0.
- FIFO full, rx_status of 0x55 in the same cycle as a DATA load:
  - load returns the oldest byte, no overflow, count stays 16;
  - 0x55 comes out last.
- Write 0x8 (ien) to an empty FIFO:
  - irq=0;
  - strobe 0x31 -> irq=1 in the next cycle;
  - DATA load -> irq=0 in the cycle after.
- With 5 bytes queued, write 0x10 (flush) in the same cycle as an rx_status of 0x77 -> count=0, irq=0, overflow=0.
- With 5 bytes queued, assert reset for 1 cycle -> all outputs return to their reset values.

Source files
------------

// File: rtl/cpu_uart_pkg.sv
// Shared definitions for the UART receive FIFO peripheral: register offsets,
// STATUS bit positions and a helper that assembles the STATUS read word.
package cpu_uart_pkg;

  localparam int unsigned BUS_W          = 32;
  localparam int unsigned BYTE_W         = 8;

  // Register byte offsets from BASE_ADDR
  localparam int unsigned REG_DATA_OFF   = 0;
  localparam int unsigned REG_STATUS_OFF = 4;

  // STATUS bit positions
  localparam int unsigned STAT_NONEMPTY  = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_IEN       = 3;
  localparam int unsigned STAT_FLUSH     = 4;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_COUNT_W   = 9;

  // Assemble the STATUS read word; unlisted bits read as zero.
  function automatic logic [BUS_W-1:0] pack_status(
    input logic [STAT_COUNT_W-1:0] count,
    input logic                    ien,
    input logic                    ovf,
    input logic                    full,
    input logic                    nonempty
  );
    logic [BUS_W-1:0] w;
    w = '0;
    w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    w[STAT_IEN]      = ien;
    w[STAT_OVF]      = ovf;
    w[STAT_FULL]     = full;
    w[STAT_NONEMPTY] = nonempty;
    return w;
  endfunction

endpackage

// File: rtl/cpu_uart_rx_fifo_if.sv
// Bus bundle for the UART receive FIFO peripheral.
//   rx_status/rx_data : receiver byte strobe and byte
//   addr/wdata/mem_rd/mem_wr : CPU memory-mapped access
//   rdata : combinational read data, irq : level interrupt
// master = CPU/receiver side, slave = peripheral side.
interface cpu_uart_rx_fifo_if;
  import cpu_uart_pkg::*;

  logic              rx_status;
  logic [BYTE_W-1:0] rx_data;
  logic [BUS_W-1:0]  addr;
  logic [BUS_W-1:0]  wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [BUS_W-1:0]  rdata;
  logic              irq;

  modport master (
    output rx_status, rx_data, addr, wdata, mem_rd, mem_wr,
    input  rdata, irq
  );

  modport slave (
    input  rx_status, rx_data, addr, wdata, mem_rd, mem_wr,
    output rdata, irq
  );
endinterface

// File: rtl/cpu_fifo_core.sv
// Generic synchronous circular FIFO with zero-latency head read.
//   clk, reset      : clock, synchronous active-high reset
//   push, wr_data   : write at tail (accepted if not full, or full with pop)
//   pop             : advance head (no-op when empty)
//   flush           : clear pointers and count; wins over push/pop
//   rd_data         : head entry, valid whenever !empty
//   count/full/empty: occupancy from registered state
//   empty_next_c    : emptiness after the coming edge
module cpu_fifo_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             empty_next_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  // Next-state: flush first, then independent push/pop.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != '0);
    // When full, a same-cycle pop frees the head slot, which is the tail slot.
    push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = wr_data;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop_ok) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rd_data      = mem_q[head_q];
  assign count        = count_q;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign empty_next_c = reset || (count_d == '0);

endmodule

// File: rtl/cpu_uart_rx_fifo.sv
// UART receive byte buffer on the CPU peripheral bus.
//   clk, reset : CPU clock, synchronous active-high reset
//   bus        : receiver strobe/byte in, CPU load/store in, rdata/irq out
// DATA at BASE_ADDR pops the head on a load; STATUS at BASE_ADDR+4 reports
// count/ien/overflow/full/nonempty and accepts overflow-clear, ien, flush.
module cpu_uart_rx_fifo
  import cpu_uart_pkg::*;
#(
  parameter int unsigned     DEPTH     = 16,
  parameter logic [BUS_W-1:0] BASE_ADDR = 32'h4000_0020
) (
  input  logic               clk,
  input  logic               reset,
  cpu_uart_rx_fifo_if.slave  bus
);

  localparam int unsigned     CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [BUS_W-1:0] DATA_ADDR = BASE_ADDR + BUS_W'(REG_DATA_OFF);
  localparam logic [BUS_W-1:0] STAT_ADDR = BASE_ADDR + BUS_W'(REG_STATUS_OFF);

  logic              data_sel_c;
  logic              stat_sel_c;
  logic              stat_wr_c;
  logic              pop_c;
  logic              flush_c;
  logic              ovf_set_c;
  logic              ovf_clr_c;
  logic [BUS_W-1:0]  rdata_c;
  logic              unused_wdata_c;

  logic [BYTE_W-1:0] head_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              empty_next_c;

  logic              ovf_q, ovf_d;
  logic              ien_q, ien_d;
  logic              irq_q, irq_d;

  cpu_fifo_core #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (bus.rx_status),
    .pop          (pop_c),
    .flush        (flush_c),
    .wr_data      (bus.rx_data),
    .rd_data      (head_data),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .empty_next_c (empty_next_c)
  );

  // Address decode, control register next-state and read mux.
  always_comb begin
    data_sel_c = (bus.addr == DATA_ADDR);
    stat_sel_c = (bus.addr == STAT_ADDR);
    stat_wr_c  = bus.mem_wr && stat_sel_c;
    pop_c      = bus.mem_rd && data_sel_c && !empty;
    flush_c    = stat_wr_c && bus.wdata[STAT_FLUSH];
    ovf_clr_c  = stat_wr_c && bus.wdata[STAT_OVF];
    // A dropped byte needs full with no freeing pop; a flush discards it silently.
    ovf_set_c  = bus.rx_status && full && !pop_c && !flush_c;

    ovf_d = ovf_q;
    if (ovf_clr_c) ovf_d = 1'b0;
    if (ovf_set_c) ovf_d = 1'b1;

    ien_d = stat_wr_c ? bus.wdata[STAT_IEN] : ien_q;
    irq_d = ien_d && !empty_next_c;

    rdata_c = '0;
    if (bus.mem_rd && data_sel_c && !empty) begin
      rdata_c = {(BUS_W - BYTE_W)'(0), head_data};
    end else if (bus.mem_rd && stat_sel_c) begin
      rdata_c = pack_status(STAT_COUNT_W'(count), ien_q, ovf_q, full, !empty);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      ien_q <= ien_d;
      irq_q <= irq_d;
    end
  end

  assign unused_wdata_c = ^{bus.wdata[31:5], bus.wdata[1:0]};

  assign bus.rdata = rdata_c;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_cpu_uart_rx_fifo.sv
// Self-checking bench for cpu_uart_rx_fifo: expected bytes go into a queue
// when strobed and are compared as DATA loads return them.
module tb_cpu_uart_rx_fifo;

  localparam int unsigned  DEPTH  = 16;
  localparam logic [31:0]  DATA_A = 32'h4000_0020;
  localparam logic [31:0]  STAT_A = 32'h4000_0024;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [7:0] sb[$];
  logic [31:0] exp_w;

  cpu_uart_rx_fifo_if bus_if();

  cpu_uart_rx_fifo #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (DATA_A)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bus cycle at the falling edge; outputs settle 1ns later.
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic rxs, input logic [7:0] rxd);
    @(negedge clk);
    bus_if.mem_rd    = rd;
    bus_if.mem_wr    = wr;
    bus_if.addr      = a;
    bus_if.wdata     = wd;
    bus_if.rx_status = rxs;
    bus_if.rx_data   = rxd;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic strobe(input logic [7:0] b);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, b);
    if (sb.size() < DEPTH) sb.push_back(b);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'h99);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    sb.delete();
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0) begin
      bad++; $display("FAIL reset_status got=%h exp=%h", bus_if.rdata, 32'h0);
    end
    total++;
    if (bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL reset_irq got=%b exp=0", bus_if.irq);
    end
    cyc(1'b1, 1'b0, DATA_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=%h", bus_if.rdata, 32'h0);
    end
  endtask

  task automatic test_basic();
    strobe(8'h41); strobe(8'h42); strobe(8'h43);
    cyc(1'b0, 1'b1, DATA_A, 32'hFF, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0000_0301) begin
      bad++; $display("FAIL basic_status got=%h exp=%h", bus_if.rdata, 32'h0000_0301);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, DATA_A, 32'h0, 1'b0, 8'h00);
      exp_w = {24'h0, sb.pop_front()};
      total++;
      if (bus_if.rdata !== exp_w) begin
        bad++; $display("FAIL basic_data%0d got=%h exp=%h", i, bus_if.rdata, exp_w);
      end
    end
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0) begin
      bad++; $display("FAIL basic_status_empty got=%h exp=%h", bus_if.rdata, 32'h0);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) strobe(8'(i));
    strobe(8'hAA);
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0000_1007) begin
      bad++; $display("FAIL ovf_status got=%h exp=%h", bus_if.rdata, 32'h0000_1007);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, DATA_A, 32'h0, 1'b0, 8'h00);
      exp_w = {24'h0, sb.pop_front()};
      total++;
      if (bus_if.rdata !== exp_w) begin
        bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, bus_if.rdata, exp_w);
      end
    end
    cyc(1'b1, 1'b0, DATA_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0) begin
      bad++; $display("FAIL ovf_dropped_byte got=%h exp=%h", bus_if.rdata, 32'h0);
    end
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0000_0004) begin
      bad++; $display("FAIL ovf_sticky got=%h exp=%h", bus_if.rdata, 32'h0000_0004);
    end
    cyc(1'b0, 1'b1, STAT_A, 32'h4, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0) begin
      bad++; $display("FAIL ovf_clear got=%h exp=%h", bus_if.rdata, 32'h0);
    end
  endtask

  task automatic test_ovf_race();
    for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i));
    // clear and new overflow in one cycle: set wins
    cyc(1'b0, 1'b1, STAT_A, 32'h4, 1'b1, 8'h66);
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0000_1007) begin
      bad++; $display("FAIL race_status got=%h exp=%h", bus_if.rdata, 32'h0000_1007);
    end
    cyc(1'b0, 1'b1, STAT_A, 32'h14, 1'b0, 8'h00);
    sb.delete();
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0) begin
      bad++; $display("FAIL race_flush_clear got=%h exp=%h", bus_if.rdata, 32'h0);
    end
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 16; i++) strobe(8'(8'h80 + i));
    cyc(1'b1, 1'b0, DATA_A, 32'h0, 1'b1, 8'h55);
    exp_w = {24'h0, sb.pop_front()};
    sb.push_back(8'h55);
    total++;
    if (bus_if.rdata !== exp_w) begin
      bad++; $display("FAIL fpp_data got=%h exp=%h", bus_if.rdata, exp_w);
    end
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0000_1003) begin
      bad++; $display("FAIL fpp_status got=%h exp=%h", bus_if.rdata, 32'h0000_1003);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, DATA_A, 32'h0, 1'b0, 8'h00);
      exp_w = {24'h0, sb.pop_front()};
      total++;
      if (bus_if.rdata !== exp_w) begin
        bad++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, bus_if.rdata, exp_w);
      end
    end
  endtask

  task automatic test_irq();
    cyc(1'b0, 1'b1, STAT_A, 32'h8, 1'b0, 8'h00);
    idle();
    total++;
    if (bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL irq_empty got=%b exp=0", bus_if.irq);
    end
    strobe(8'h31);
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.irq !== 1'b1) begin
      bad++; $display("FAIL irq_rise got=%b exp=1", bus_if.irq);
    end
    total++;
    if (bus_if.rdata !== 32'h0000_0109) begin
      bad++; $display("FAIL irq_status got=%h exp=%h", bus_if.rdata, 32'h0000_0109);
    end
    cyc(1'b1, 1'b0, DATA_A, 32'h0, 1'b0, 8'h00);
    exp_w = {24'h0, sb.pop_front()};
    total++;
    if (bus_if.rdata !== exp_w) begin
      bad++; $display("FAIL irq_data got=%h exp=%h", bus_if.rdata, exp_w);
    end
    idle();
    total++;
    if (bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL irq_fall got=%b exp=0", bus_if.irq);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) strobe(8'(8'h60 + i));
    idle();
    total++;
    if (bus_if.irq !== 1'b1) begin
      bad++; $display("FAIL flush_irq_before got=%b exp=1", bus_if.irq);
    end
    // flush with ien kept set, byte strobed in the same cycle is discarded
    cyc(1'b0, 1'b1, STAT_A, 32'h18, 1'b1, 8'h77);
    sb.delete();
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0000_0008) begin
      bad++; $display("FAIL flush_status got=%h exp=%h", bus_if.rdata, 32'h0000_0008);
    end
    total++;
    if (bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL flush_irq got=%b exp=0", bus_if.irq);
    end
    cyc(1'b1, 1'b0, DATA_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0) begin
      bad++; $display("FAIL flush_data got=%h exp=%h", bus_if.rdata, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) strobe(8'(8'hC0 + i));
    idle();
    total++;
    if (bus_if.irq !== 1'b1) begin
      bad++; $display("FAIL rstmid_irq_before got=%b exp=1", bus_if.irq);
    end
    reset = 1'b1;
    idle();
    reset = 1'b0;
    sb.delete();
    cyc(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0) begin
      bad++; $display("FAIL rstmid_status got=%h exp=%h", bus_if.rdata, 32'h0);
    end
    total++;
    if (bus_if.irq !== 1'b0) begin
      bad++; $display("FAIL rstmid_irq got=%b exp=0", bus_if.irq);
    end
    cyc(1'b1, 1'b0, DATA_A, 32'h0, 1'b0, 8'h00);
    total++;
    if (bus_if.rdata !== 32'h0) begin
      bad++; $display("FAIL rstmid_data got=%h exp=%h", bus_if.rdata, 32'h0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus_if.mem_rd    = 1'b0;
    bus_if.mem_wr    = 1'b0;
    bus_if.addr      = 32'h0;
    bus_if.wdata     = 32'h0;
    bus_if.rx_status = 1'b0;
    bus_if.rx_data   = 8'h00;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_ovf_race();
    test_full_pop_push();
    test_irq();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
